// File: rtl/axi4_mult_pkg.sv
// Shared types and helpers for the AXI4 multiplier scheduler.
package axi4_mult_pkg;

   typedef enum logic [2:0] {
      IDLE, AW, W, B, AR, R, RSP
   } state_t;

   function automatic int beats(input int sz, input int dsz);
      return 2 * sz / dsz;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/axi4_mult_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);

   localparam int IW = $clog2(N);

   // Scan downward so the lowest offset from the pointer wins last.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[(int'(ptr_i) + i) % N])
            idx_o = IW'((int'(ptr_i) + i) % N);
      end
      any_o = |req_i;
      gnt_o = '0;
      if (any_o)
         gnt_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/axi4_mult_scheduler.sv
// Shares one AXI4 multiplier slave among NREQ requesters, one op in flight.
// Optional ERR_RETRY_EN: replay the AW..R sequence once after an error.
import axi4_mult_pkg::*;

module axi4_mult_scheduler #(
   parameter int NREQ = 4,
   parameter int SZ   = 32,
   parameter int ASZ  = 2,
   parameter int DSZ  = 8
) (
   input  logic                    clk,
   input  logic                    _rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*SZ-1:0]      req_a,
   input  logic [NREQ*SZ-1:0]      req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2*SZ-1:0]         rsp_data,
   output logic                    rsp_ok,
   output logic [ASZ-1:0]          awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DSZ-1:0]          wdata,
   output logic                    wvalid,
   input  logic                    wready,
   output logic                    wlast,
   input  logic                    bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ASZ-1:0]          araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DSZ-1:0]          rdata,
   input  logic                    rvalid,
   output logic                    rready,
   input  logic                    rlast,
   input  logic                    rresp
);

   localparam int WBEATS = beats(SZ, DSZ);
   localparam int RBEATS = beats(SZ, DSZ);
   localparam int CW     = cnt_w(RBEATS);
   localparam int IW     = $clog2(NREQ);

   state_t            state_q;
   logic [IW-1:0]     ptr_q;
   logic [2*SZ-1:0]   opnd_q;
   logic [2*SZ-1:0]   result_q;
   logic [CW-1:0]     cnt_q;
   logic              err_q;
   logic [NREQ-1:0]   req_ready_q;
   logic              rsp_valid_q;
   logic [IW-1:0]     rsp_id_q;
   logic              rsp_ok_q;
   logic              awvalid_q;
   logic [DSZ-1:0]    wdata_q;
   logic              wvalid_q;
   logic              wlast_q;
   logic              bready_q;
   logic              arvalid_q;
   logic              rready_q;

   logic [NREQ-1:0]   gnt;
   logic [IW-1:0]     gidx;
   logic              gany;
   logic              r_over;
   logic              r_last_beat;
   logic              err_nxt;
   logic              retry_go;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gidx),
      .any_o (gany)
   );

   assign r_over      = (cnt_q >= CW'(RBEATS));
   assign r_last_beat = (cnt_q == CW'(RBEATS - 1));
   assign err_nxt     = err_q | ~rresp | r_over | (rlast ^ r_last_beat);

`ifdef ERR_RETRY_EN
   logic retry_q;
   assign retry_go = err_nxt & ~retry_q;
`else
   assign retry_go = 1'b0;
`endif

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         opnd_q      <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         req_ready_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_ok_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wdata_q     <= '0;
         wvalid_q    <= 1'b0;
         wlast_q     <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
`ifdef ERR_RETRY_EN
         retry_q     <= 1'b0;
`endif
      end else begin
         req_ready_q <= '0;
         unique case (state_q)
            IDLE: if (gany) begin
               req_ready_q <= gnt;
               opnd_q      <= {req_b[int'(gidx)*SZ +: SZ],
                               req_a[int'(gidx)*SZ +: SZ]};
               rsp_id_q    <= gidx;
               ptr_q       <= IW'((int'(gidx) + 1) % NREQ);
               err_q       <= 1'b0;
               awvalid_q   <= 1'b1;
               state_q     <= AW;
`ifdef ERR_RETRY_EN
               retry_q     <= 1'b0;
`endif
            end
            AW: if (awready) begin
               awvalid_q <= 1'b0;
               wvalid_q  <= 1'b1;
               wdata_q   <= opnd_q[DSZ-1:0];
               wlast_q   <= (WBEATS == 1);
               cnt_q     <= '0;
               state_q   <= W;
            end
            W: if (wready) begin
               if (int'(cnt_q) == WBEATS - 1) begin
                  wvalid_q <= 1'b0;
                  wlast_q  <= 1'b0;
                  bready_q <= 1'b1;
                  state_q  <= B;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
                  wdata_q <= opnd_q[(int'(cnt_q) + 1)*DSZ +: DSZ];
                  wlast_q <= (int'(cnt_q) == WBEATS - 2);
               end
            end
            B: if (bvalid) begin
               err_q     <= err_q | ~bresp;
               bready_q  <= 1'b0;
               arvalid_q <= 1'b1;
               state_q   <= AR;
            end
            AR: if (arready) begin
               arvalid_q <= 1'b0;
               rready_q  <= 1'b1;
               cnt_q     <= '0;
               state_q   <= R;
            end
            R: if (rvalid) begin
               if (!r_over) begin
                  result_q[int'(cnt_q)*DSZ +: DSZ] <= rdata;
                  cnt_q <= cnt_q + 1'b1;
               end
               err_q <= err_nxt;
               if (rlast) begin
                  rready_q <= 1'b0;
                  if (retry_go) begin
                     err_q     <= 1'b0;
                     awvalid_q <= 1'b1;
                     state_q   <= AW;
`ifdef ERR_RETRY_EN
                     retry_q   <= 1'b1;
`endif
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_ok_q    <= ~err_nxt;
                     state_q     <= RSP;
                  end
               end
            end
            RSP: if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = result_q;
   assign rsp_ok    = rsp_ok_q;
   assign awaddr    = '0;
   assign awvalid   = awvalid_q;
   assign wdata     = wdata_q;
   assign wvalid    = wvalid_q;
   assign wlast     = wlast_q;
   assign bready    = bready_q;
   assign araddr    = '0;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;

endmodule

// File: tb/tb_axi4_mult_scheduler.sv
// Scoreboard bench for axi4_mult_scheduler with a behavioural AXI slave.
module tb_axi4_mult_scheduler;

   localparam int NREQ = 4;
   localparam int SZ   = 32;
   localparam int ASZ  = 2;
   localparam int DSZ  = 8;
`ifdef ERR_RETRY_EN
   localparam logic RETRY = 1'b1;
`else
   localparam logic RETRY = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              _rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*SZ-1:0] req_a;
   logic [NREQ*SZ-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [2*SZ-1:0]   rsp_data;
   logic              rsp_ok;
   logic [ASZ-1:0]    awaddr;
   logic              awvalid;
   logic              awready;
   logic [DSZ-1:0]    wdata;
   logic              wvalid;
   logic              wready;
   logic              wlast;
   logic              bresp;
   logic              bvalid;
   logic              bready;
   logic [ASZ-1:0]    araddr;
   logic              arvalid;
   logic              arready;
   logic [DSZ-1:0]    rdata;
   logic              rvalid;
   logic              rready;
   logic              rlast;
   logic              rresp;

   always #5 clk = ~clk;

   axi4_mult_scheduler #(
      .NREQ(NREQ), .SZ(SZ), .ASZ(ASZ), .DSZ(DSZ)
   ) dut (
      .clk(clk), ._rst(_rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ok(rsp_ok),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .rlast(rlast), .rresp(rresp)
   );

   // Behavioural slave: accepts 8 operand bytes, returns a*b as 8 bytes.
   logic [63:0] s_wbuf;
   logic [63:0] s_prod;
   int          s_wcnt;
   int          s_rcnt;
   int          s_awcnt;
   int          s_bcnt;
   logic        bad_b_on = 1'b0;
   int          bad_b_idx = 0;

   assign awready = 1'b1;
   assign wready  = 1'b1;
   assign arready = 1'b1;
   assign bresp   = !(bad_b_on && s_bcnt == bad_b_idx);
   assign rdata   = s_prod[s_rcnt*8 +: 8];
   assign rlast   = (s_rcnt == 7);
   assign rresp   = 1'b1;

   always @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         s_wbuf  <= '0;
         s_prod  <= '0;
         s_wcnt  <= 0;
         s_rcnt  <= 0;
         s_awcnt <= 0;
         s_bcnt  <= 0;
         bvalid  <= 1'b0;
         rvalid  <= 1'b0;
      end else begin
         if (awvalid && awready)
            s_awcnt <= s_awcnt + 1;
         if (wvalid && wready) begin
            s_wbuf[s_wcnt*8 +: 8] <= wdata;
            if (s_wcnt == 7) begin
               s_wcnt <= 0;
               bvalid <= 1'b1;
            end else begin
               s_wcnt <= s_wcnt + 1;
            end
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0;
            s_bcnt <= s_bcnt + 1;
         end
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            s_rcnt <= 0;
            s_prod <= 64'(s_wbuf[31:0]) * 64'(s_wbuf[63:32]);
         end
         if (rvalid && rready) begin
            if (s_rcnt == 7)
               rvalid <= 1'b0;
            else
               s_rcnt <= s_rcnt + 1;
         end
      end
   end

   typedef struct packed {
      logic [1:0]  id;
      logic [63:0] data;
      logic        ok;
   } rsp_t;

   rsp_t        rq[$];
   int          gq[$];
   logic [7:0]  wq[$];
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Monitor: grants, write beats and responses against the queues.
   initial begin
      rsp_t e;
      int   g;
      forever begin
         @(negedge clk);
         if (_rst) begin
            if (req_ready != '0) begin
               if (gq.size() == 0) begin
                  chk("grant_unexpected", 64'(req_ready), 64'd0);
               end else begin
                  g = gq.pop_front();
                  chk("grant", 64'(req_ready), 64'd1 << g);
               end
            end
            if (wvalid && wready) begin
               chk("wlast", 64'(wlast), 64'(s_wcnt == 7));
               if (wq.size() > 0)
                  chk("wdata", 64'(wdata), 64'(wq.pop_front()));
            end
            if (rsp_valid && rsp_ready) begin
               if (rq.size() == 0) begin
                  chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
               end else begin
                  e = rq.pop_front();
                  chk("rsp_id", 64'(rsp_id), 64'(e.id));
                  chk("rsp_data", rsp_data, e.data);
                  chk("rsp_ok", 64'(rsp_ok), 64'(e.ok));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~req_ready;
   endtask

   task automatic issue(input int i, input logic [31:0] a,
                        input logic [31:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 400; k++) begin
         if (req_valid == '0 && rq.size() == 0 && gq.size() == 0 &&
             !rsp_valid)
            break;
         tick();
      end
      chk(nm, 64'(rq.size() + gq.size() + int'(req_valid != '0)), 64'd0);
   endtask

   task automatic do_reset();
      _rst = 1'b0;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      _rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int aw0;
      _rst = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", 64'({req_ready, rsp_valid, rsp_id, rsp_ok, awvalid,
          awaddr, wdata, wvalid, wlast, bready, araddr, arvalid, rready}),
          64'd0);
      chk("reset_data", rsp_data, 64'd0);
      _rst = 1'b1;

      // 3 * 5 with exact write beat order
      issue(0, 32'h3, 32'h5);
      gq.push_back(0);
      rq.push_back({2'd0, 64'hF, 1'b1});
      wq.push_back(8'h03); wq.push_back(8'h00);
      wq.push_back(8'h00); wq.push_back(8'h00);
      wq.push_back(8'h05); wq.push_back(8'h00);
      wq.push_back(8'h00); wq.push_back(8'h00);
      drain("drain_t1");

      // all-ones operands
      issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      gq.push_back(1);
      rq.push_back({2'd1, 64'hFFFF_FFFE_0000_0001, 1'b1});
      drain("drain_t2");

      // round-robin order from a fresh pointer
      do_reset();
      issue(0, 32'h2, 32'h3);
      issue(2, 32'h10, 32'h20);
      gq.push_back(0); gq.push_back(2);
      rq.push_back({2'd0, 64'h6, 1'b1});
      rq.push_back({2'd2, 64'h200, 1'b1});
      drain("drain_t3a");
      issue(0, 32'h100, 32'h100);
      issue(3, 32'h9, 32'h9);
      gq.push_back(3); gq.push_back(0);
      rq.push_back({2'd3, 64'd81, 1'b1});
      rq.push_back({2'd0, 64'h10000, 1'b1});
      drain("drain_t3b");

      // response back-pressure with another request pending
      rsp_ready = 1'b0;
      issue(0, 32'd4, 32'd5);
      gq.push_back(0); gq.push_back(1);
      rq.push_back({2'd0, 64'd20, 1'b1});
      rq.push_back({2'd1, 64'd42, 1'b1});
      for (int k = 0; k < 50; k++) begin
         tick();
         if (req_ready[0]) break;
      end
      issue(1, 32'd6, 32'd7);
      for (int k = 0; k < 100; k++) begin
         if (rsp_valid) break;
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         chk("stall_ctl", 64'({rsp_valid, rsp_id, req_ready}),
             64'({1'b1, 2'd0, 4'd0}));
         chk("stall_data", rsp_data, 64'd20);
         tick();
      end
      rsp_ready = 1'b1;
      drain("drain_t4");

      // slave reports a write error on this operation's first B
      aw0 = s_awcnt;
      bad_b_idx = s_bcnt;
      bad_b_on = 1'b1;
      issue(2, 32'h1234, 32'h10);
      gq.push_back(2);
      rq.push_back({2'd2, 64'h12340, RETRY});
      drain("drain_t5");
      chk("aw_count", 64'(s_awcnt - aw0), RETRY ? 64'd2 : 64'd1);
      bad_b_on = 1'b0;

      // asynchronous reset during the third write beat
      issue(1, 32'h1, 32'h1);
      gq.push_back(1);
      for (int k = 0; k < 100; k++) begin
         if (s_wcnt == 2 && wvalid) break;
         tick();
      end
      _rst = 1'b0;
      #1;
      chk("arst_ctrl", 64'({req_ready, rsp_valid, rsp_id, rsp_ok, awvalid,
          awaddr, wdata, wvalid, wlast, bready, araddr, arvalid, rready}),
          64'd0);
      chk("arst_data", rsp_data, 64'd0);
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      _rst = 1'b1;
      issue(3, 32'd7, 32'd6);
      gq.push_back(3);
      rq.push_back({2'd3, 64'd42, 1'b1});
      drain("drain_t6");

      repeat (3) tick();
      chk("queues_empty", 64'(rq.size() + gq.size() + wq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
